// File: rtl/bbpd_loop_filter.sv
// Bang-bang PD loop filter: majority vote over DECIM samples,
// then a saturating proportional-integral update of the control code.
module bbpd_loop_filter #(
  parameter int DECIM     = 8,
  parameter int OUT_W     = 10,
  parameter int FRAC_W    = 6,
  parameter int KP        = 4,
  parameter int KI        = 8,
  parameter int INIT_CODE = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             dn,
  output logic [OUT_W-1:0] code,
  output logic             code_valid,
  output logic             sat
);

  localparam int INT_W = OUT_W + FRAC_W;
  localparam int CW    = $clog2(DECIM);
  localparam int SW    = CW + 2;
  localparam int AW    = INT_W + 2;

  localparam logic [CW-1:0]    CNT_LAST   = CW'(DECIM - 1);
  localparam logic [INT_W-1:0] INTEG_MAX  = '1;
  localparam logic [INT_W-1:0] INTEG_INIT = INT_W'(INIT_CODE << FRAC_W);
  localparam logic [OUT_W-1:0] CODE_INIT  = OUT_W'(INIT_CODE);
  localparam logic             SAT_INIT   =
    (INTEG_INIT == '0) || (INTEG_INIT == INTEG_MAX);

  localparam logic signed [AW-1:0] KI_A  = AW'(KI);
  localparam logic signed [AW-1:0] KP_A  = AW'(KP);
  localparam logic signed [AW-1:0] IMAX_A =
    signed'({2'b00, INTEG_MAX});
  localparam logic signed [AW-1:0] CMAX_A =
    signed'({{(AW-OUT_W){1'b0}}, {OUT_W{1'b1}}});

  logic        [CW-1:0]    cnt;
  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    v;
  logic signed [SW-1:0]    sum_nxt;
  logic signed [1:0]       dec_r;
  logic signed [1:0]       dec_nxt;
  logic                    pend;
  logic                    last;
  logic        [INT_W-1:0] integ;
  logic        [INT_W-1:0] integ_new;
  logic        [OUT_W-1:0] code_new;
  logic signed [AW-1:0]    ki_term;
  logic signed [AW-1:0]    kp_term;
  logic signed [AW-1:0]    integ_sum;
  logic signed [AW-1:0]    code_sum;

  // Both-high is treated as noise and votes zero
  always_comb begin
    v = '0;
    unique case (1'b1)
      up && !dn: v = SW'(1);
      dn && !up: v = -SW'(1);
      default:   v = '0;
    endcase
  end

  assign sum_nxt = sum + v;
  assign last    = (cnt == CNT_LAST);

  always_comb begin
    dec_nxt = 2'sb00;
    if (sum_nxt > 0)
      dec_nxt = 2'sb01;
    else if (sum_nxt < 0)
      dec_nxt = 2'sb11;
  end

  always_comb begin
    ki_term = '0;
    kp_term = '0;
    unique case (dec_r)
      2'sb01: begin
        ki_term = KI_A;
        kp_term = KP_A;
      end
      2'sb11: begin
        ki_term = -KI_A;
        kp_term = -KP_A;
      end
      default: begin
        ki_term = '0;
        kp_term = '0;
      end
    endcase
  end

  // Wide signed sums, then clamp to the unsigned rails
  always_comb begin
    integ_sum = signed'({2'b00, integ}) + ki_term;
    integ_new = integ_sum[INT_W-1:0];
    if (integ_sum < 0)
      integ_new = '0;
    else if (integ_sum > IMAX_A)
      integ_new = INTEG_MAX;

    code_sum = signed'({{(AW-OUT_W){1'b0}}, integ_new[INT_W-1:FRAC_W]})
             + kp_term;
    code_new = code_sum[OUT_W-1:0];
    if (code_sum < 0)
      code_new = '0;
    else if (code_sum > CMAX_A)
      code_new = {OUT_W{1'b1}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      sum   <= '0;
      dec_r <= 2'sb00;
      pend  <= 1'b0;
    end else begin
      pend <= en && last;
      if (en) begin
        if (last) begin
          dec_r <= dec_nxt;
          cnt   <= '0;
          sum   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
          sum <= sum_nxt;
        end
      end
    end
  end

  // Update stage runs on the edge after a window closes, even with en low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ      <= INTEG_INIT;
      code       <= CODE_INIT;
      code_valid <= 1'b0;
      sat        <= SAT_INIT;
    end else begin
      code_valid <= pend;
      if (pend) begin
        integ <= integ_new;
        code  <= code_new;
        sat   <= (integ_new == '0) || (integ_new == INTEG_MAX);
      end
    end
  end

endmodule

// File: tb/tb_bbpd_loop_filter.sv
// Directed bench for bbpd_loop_filter: default instance plus a
// near-rail instance (INIT_CODE=1020) for saturation behaviour.
module tb_bbpd_loop_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       up  = 1'b0;
  logic       dn  = 1'b0;
  logic [9:0] code;
  logic       code_valid;
  logic       sat;
  logic [9:0] code_hi;
  logic       code_valid_hi;
  logic       sat_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bbpd_loop_filter dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up         (up),
    .dn         (dn),
    .code       (code),
    .code_valid (code_valid),
    .sat        (sat)
  );

  bbpd_loop_filter #(.INIT_CODE(1020)) dut_hi (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up         (up),
    .dn         (dn),
    .code       (code_hi),
    .code_valid (code_valid_hi),
    .sat        (sat_hi)
  );

  // Drive at the falling edge, observe 1 time unit after the rising edge
  task automatic step(input logic u, input logic d, input logic e);
    @(negedge clk);
    up = u;
    dn = d;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    up  = 1'b0;
    dn  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int early;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    checks++;
    if (code !== 10'd512 || code_valid !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL async_reset code=%0d valid=%b sat=%b want 512 0 0",
               code, code_valid, sat);
    end
    @(negedge clk);
    rst = 1'b0;
    early = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (code_valid) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL reset_no_early_strobe got %0d strobes want 0", early);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (code_valid !== 1'b1 || code !== 10'd516) begin
      errors++;
      $display("FAIL reset_full_window valid=%b code=%0d want 1 516",
               code_valid, code);
    end
  endtask

  task automatic test_up_windows();
    int strobes;
    do_reset();
    strobes = 0;
    for (int i = 1; i <= 65; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (code_valid) strobes++;
      if (i == 9) begin
        checks++;
        if (code_valid !== 1'b1 || code !== 10'd516 ||
            dut.integ !== 16'd32776) begin
          errors++;
          $display("FAIL up_first valid=%b code=%0d integ=%0d want 1 516 32776",
                   code_valid, code, dut.integ);
        end
      end
    end
    checks++;
    if (strobes != 8 || code !== 10'd517 || dut.integ !== 16'd32832) begin
      errors++;
      $display("FAIL up_8win strobes=%0d code=%0d integ=%0d want 8 517 32832",
               strobes, code, dut.integ);
    end
  endtask

  task automatic test_alternate();
    int strobes;
    int bad;
    do_reset();
    strobes = 0;
    bad = 0;
    for (int i = 1; i <= 33; i++) begin
      if (i == 33) step(1'b0, 1'b0, 1'b0);
      else if (i % 2 == 1) step(1'b1, 1'b0, 1'b1);
      else step(1'b0, 1'b1, 1'b1);
      if (code_valid) begin
        strobes++;
        if (i % 8 != 1 || code !== 10'd512) bad++;
      end
    end
    checks++;
    if (strobes != 4 || bad != 0 || dut.integ !== 16'd32768) begin
      errors++;
      $display("FAIL alternate strobes=%0d bad=%0d integ=%0d want 4 0 32768",
               strobes, bad, dut.integ);
    end
  endtask

  task automatic test_votes();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (code_valid !== 1'b1 || code !== 10'd512) begin
      errors++;
      $display("FAIL both_high valid=%b code=%0d want 1 512",
               code_valid, code);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 5) step(1'b1, 1'b0, 1'b1);
      else step(1'b0, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (code_valid !== 1'b1 || code !== 10'd516) begin
      errors++;
      $display("FAIL mixed_5up_3dn valid=%b code=%0d want 1 516",
               code_valid, code);
    end
  endtask

  task automatic test_sat();
    do_reset();
    checks++;
    if (code_hi !== 10'd1020 || sat_hi !== 1'b0) begin
      errors++;
      $display("FAIL sat_reset code=%0d sat=%b want 1020 0", code_hi, sat_hi);
    end
    for (int i = 1; i <= 264; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i == 9) begin
        checks++;
        if (code_hi !== 10'd1023 || sat_hi !== 1'b0) begin
          errors++;
          $display("FAIL sat_code_clamp code=%0d sat=%b want 1023 0",
                   code_hi, sat_hi);
        end
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (code_hi !== 10'd1023 || sat_hi !== 1'b1 ||
        dut_hi.integ !== 16'd65535) begin
      errors++;
      $display("FAIL sat_rail code=%0d sat=%b integ=%0d want 1023 1 65535",
               code_hi, sat_hi, dut_hi.integ);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (code_valid_hi !== 1'b1 || code_hi !== 10'd1019 ||
        sat_hi !== 1'b0 || dut_hi.integ !== 16'd65527) begin
      errors++;
      $display("FAIL sat_release valid=%b code=%0d sat=%b integ=%0d want 1 1019 0 65527",
               code_valid_hi, code_hi, sat_hi, dut_hi.integ);
    end
  endtask

  task automatic test_en_gap();
    int strobes;
    do_reset();
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (code_valid) strobes++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (code_valid) strobes++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (code_valid) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL en_gap_early got %0d strobes want 0", strobes);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (code_valid !== 1'b1 || code !== 10'd516 ||
        dut.integ !== 16'd32776) begin
      errors++;
      $display("FAIL en_gap_result valid=%b code=%0d integ=%0d want 1 516 32776",
               code_valid, code, dut.integ);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (code_valid !== 1'b1 || code !== 10'd516) begin
      errors++;
      $display("FAIL b2b_first valid=%b code=%0d want 1 516", code_valid, code);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (code_valid !== 1'b1 || code !== 10'd508 ||
        dut.integ !== 16'd32768) begin
      errors++;
      $display("FAIL b2b_second valid=%b code=%0d integ=%0d want 1 508 32768",
               code_valid, code, dut.integ);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (code_valid !== 1'b0 || code !== 10'd508) begin
      errors++;
      $display("FAIL strobe_width valid=%b code=%0d want 0 508",
               code_valid, code);
    end
  endtask

  initial begin
    test_reset();
    test_up_windows();
    test_alternate();
    test_votes();
    test_sat();
    test_en_gap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
